// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that shares one stb/ack floating-point
// adder among NREQ requesters. One operation in flight at a time; operands and
// result pass through untouched.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_z,
  input  logic [NREQ-1:0]      resp_ack,
  output logic [31:0]          add_a,
  output logic                 add_a_stb,
  input  logic                 add_a_ack,
  output logic [31:0]          add_b,
  output logic                 add_b_stb,
  input  logic                 add_b_ack,
  input  logic [31:0]          add_z,
  input  logic                 add_z_stb,
  output logic                 add_z_ack,
  output logic                 busy,
  output logic [2:0]           grant,
  output logic [CW-1:0]        op_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESPOND
  } state_t;

  state_t     r_state;
  logic [2:0] r_last;
  logic [2:0] w_pick;
  logic       w_any;

  // Round-robin pick: the pending requester with the smallest distance past
  // r_last (distance measured modulo NREQ) wins.
  always_comb begin
    int best;
    int d;
    best   = NREQ;
    d      = 0;
    w_pick = '0;
    w_any  = |req_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = i - int'(r_last) - 1;
        if (d < 0) d = d + NREQ;
        if (d < best) begin
          best   = d;
          w_pick = 3'(i);
        end
      end
    end
  end

  // Controller FSM; every output is a register loaded on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 3'(NREQ - 1);
      req_ready  <= '0;
      resp_valid <= '0;
      resp_z     <= '0;
      add_a      <= '0;
      add_a_stb  <= 1'b0;
      add_b      <= '0;
      add_b_stb  <= 1'b0;
      add_z_ack  <= 1'b0;
      busy       <= 1'b0;
      grant      <= '0;
      op_count   <= '0;
    end else begin
      req_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant     <= w_pick;
            req_ready <= NREQ'(1) << w_pick;
            add_a     <= req_a[32*w_pick +: 32];
            add_b     <= req_b[32*w_pick +: 32];
            add_a_stb <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (add_a_stb && add_a_ack) begin
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b1;
            r_state   <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (add_b_stb && add_b_ack) begin
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b1;
            r_state   <= S_WAIT_Z;
          end
        end
        S_WAIT_Z: begin
          if (add_z_stb && add_z_ack) begin
            add_z_ack  <= 1'b0;
            resp_z     <= add_z;
            resp_valid <= NREQ'(1) << grant;
            r_state    <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          // resp_valid is one-hot on the granted lane, so this masks off
          // acks from every other requester.
          if (|(resp_ack & resp_valid)) begin
            resp_valid <= '0;
            r_last     <= grant;
            op_count   <= op_count + CW'(1);
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: random and directed scenarios for adder_arbiter against a
// behavioural adder (z = a ^ b) and a round-robin reference model.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ack;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [31:0]         resp_z, add_a, add_b, add_z;
  logic                add_a_stb, add_a_ack, add_b_stb, add_b_ack;
  logic                add_z_stb, add_z_ack, busy;
  logic [2:0]          grant;
  logic [CW-1:0]       op_count;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_z(resp_z), .resp_ack(resp_ack),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .busy(busy), .grant(grant), .op_count(op_count)
  );

  // Behavioural adder: acks A after stall_a cycles, acks B at once, presents
  // z = a ^ b after about lat + stall_z cycles. Restarts with rst.
  int lat = 3, stall_a = 0, stall_z = 0;
  int m_st = 0, m_cnt = 0;
  int n_xa = 0, n_xz = 0;
  logic [31:0] m_a, m_b;
  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0;
      add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0; add_z <= '0;
    end else begin
      case (m_st)
        0: if (add_a_stb && add_a_ack) begin
             m_a <= add_a; add_a_ack <= 1'b0; n_xa <= n_xa + 1; m_st <= 1; m_cnt <= 0;
           end else if (add_a_stb) begin
             if (m_cnt >= stall_a) add_a_ack <= 1'b1; else m_cnt <= m_cnt + 1;
           end
        1: if (add_b_stb && add_b_ack) begin
             m_b <= add_b; add_b_ack <= 1'b0; m_st <= 2; m_cnt <= 0;
           end else if (add_b_stb) add_b_ack <= 1'b1;
        2: if (m_cnt >= lat + stall_z - 2) begin
             add_z <= m_a ^ m_b; add_z_stb <= 1'b1; m_st <= 3;
           end else m_cnt <= m_cnt + 1;
        default: if (add_z_stb && add_z_ack) begin
             add_z_stb <= 1'b0; n_xz <= n_xz + 1; m_st <= 0; m_cnt <= 0;
           end
      endcase
    end
  end

  // Protocol monitor: strobes must hold until accepted; the three adder
  // handshakes must be mutually exclusive.
  logic p_astb = 0, p_aack = 0, p_zack = 0, p_zstb = 0, p_rst = 1;
  logic [31:0] p_a = '0;
  int hold_viol = 0, excl_viol = 0, a_run = 0, a_run_max = 0, z_run = 0, z_run_max = 0;
  int ready_pulses = 0;
  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (p_astb && !p_aack && !(add_a_stb && add_a == p_a)) hold_viol <= hold_viol + 1;
      if (p_zack && !p_zstb && !add_z_ack) hold_viol <= hold_viol + 1;
    end
    if (!rst) begin
      if (int'(add_a_stb) + int'(add_b_stb) + int'(add_z_ack) > 1) excl_viol <= excl_viol + 1;
      ready_pulses <= ready_pulses + $countones(req_ready);
    end
    a_run <= add_a_stb ? a_run + 1 : 0;
    z_run <= add_z_ack ? z_run + 1 : 0;
    if (a_run > a_run_max) a_run_max <= a_run;
    if (z_run > z_run_max) z_run_max <= z_run;
    p_astb <= add_a_stb; p_aack <= add_a_ack; p_zack <= add_z_ack; p_zstb <= add_z_stb;
    p_a <= add_a; p_rst <= rst;
  end

  // Reference data and observation queues.
  logic [31:0] ra [NREQ];
  logic [31:0] rb [NREQ];
  int m_last = NREQ - 1;
  int q_expg[$], q_obsg[$], q_grant[$], q_rspg[$];
  logic [31:0] q_expz[$], q_obsz[$];

  function automatic int first_set(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic new_pair(input int i, input logic [31:0] a, input logic [31:0] b);
    ra[i] = a; rb[i] = b;
    req_a[32*i +: 32] = a; req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; resp_ack = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic wait_ready(output logic ok);
    int c; c = 0;
    while (req_ready == '0 && c < 500) begin @(posedge clk); #1; c++; end
    ok = (req_ready != '0);
  endtask

  task automatic wait_resp(output logic ok);
    int c; c = 0;
    while (resp_valid == '0 && c < 500) begin @(posedge clk); #1; c++; end
    ok = (resp_valid != '0);
  endtask

  // Requester agents: each lane keeps one pair in flight, re-issues after a
  // random gap, acks results after a random delay. Expected grant and sum
  // come from the round-robin model at acceptance time.
  task automatic drive_ops(input logic [NREQ-1:0] mask, input int total,
                           input int max_ack, input int max_gap);
    int issued, done, ackw, cyc, g, e, cur;
    int gap [NREQ];
    issued = 0; done = 0; ackw = -1; cyc = 0; cur = 0;
    q_expg.delete(); q_obsg.delete(); q_grant.delete(); q_rspg.delete();
    q_expz.delete(); q_obsz.delete();
    for (int i = 0; i < NREQ; i++) begin
      gap[i] = -1;
      if (mask[i] && issued < total) begin new_pair(i, $urandom, $urandom); issued++; end
    end
    while (done < total && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      resp_ack = '0;
      if (req_ready != '0) begin
        e = rr_pick(req_valid, m_last); cur = e;
        q_expg.push_back(e); q_obsg.push_back(first_set(req_ready)); q_grant.push_back(int'(grant));
        if (e >= 0) q_expz.push_back(ra[e] ^ rb[e]); else q_expz.push_back('0);
        req_valid = req_valid & ~req_ready;
      end
      if (resp_valid != '0) begin
        if (ackw < 0) ackw = $urandom_range(0, max_ack);
        if (ackw == 0) begin
          g = first_set(resp_valid);
          q_rspg.push_back(g); q_obsz.push_back(resp_z);
          resp_ack = resp_valid; done++; m_last = cur; ackw = -1;
          if (issued < total && g >= 0) begin gap[g] = $urandom_range(0, max_gap); issued++; end
        end else ackw--;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (gap[i] == 0) begin new_pair(i, $urandom, $urandom); gap[i] = -1; end
        else if (gap[i] > 0) gap[i]--;
      end
    end
    n_cmp++;
    if (done != total) begin
      n_fail++; $display("FAIL drive_ops_timeout: completed %0d, required %0d", done, total);
    end
    @(posedge clk); #1;
    resp_ack = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({req_ready, resp_valid} !== '0) begin n_fail++;
      $display("FAIL reset_ready_valid: got %h want 0", {req_ready, resp_valid}); end
    n_cmp++; if ({add_a_stb, add_b_stb, add_z_ack, busy} !== 4'b0) begin n_fail++;
      $display("FAIL reset_strobes: got %b want 0000", {add_a_stb, add_b_stb, add_z_ack, busy}); end
    n_cmp++; if ({add_a, add_b, resp_z} !== 96'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", {add_a, add_b, resp_z}); end
    n_cmp++; if (grant !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant); end
    n_cmp++; if (op_count !== '0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
  endtask

  task automatic test_single();
    logic ok; int rp0;
    rp0 = ready_pulses;
    new_pair(0, 32'h3F800000, 32'h40000000);
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0001 || add_a_stb !== 1'b1 || add_a !== 32'h3F800000) begin n_fail++;
      $display("FAIL single_accept: ready=%b a_stb=%b a=%h want 0001/1/3f800000", req_ready, add_a_stb, add_a); end
    req_valid = '0;
    wait_resp(ok);
    n_cmp++; if (!ok || resp_valid !== 4'b0001 || resp_z !== 32'h7F800000) begin n_fail++;
      $display("FAIL single_result: valid=%b z=%h want 0001/7f800000", resp_valid, resp_z); end
    resp_ack = 4'b0001;
    @(posedge clk); #1;
    resp_ack = '0;
    n_cmp++; if (op_count !== 4'd1 || busy !== 1'b0 || resp_valid !== '0) begin n_fail++;
      $display("FAIL single_done: op_count=%0d busy=%b valid=%b want 1/0/0", op_count, busy, resp_valid); end
    n_cmp++; if (ready_pulses - rp0 !== 1) begin n_fail++;
      $display("FAIL single_ready_pulses: got %0d want 1", ready_pulses - rp0); end
  endtask

  task automatic test_rotate();
    do_reset();
    lat = $urandom_range(3, 10);
    drive_ops(4'hF, 8, 0, 0);
    n_cmp++; if (q_obsg.size() != 8 || q_rspg.size() != 8) begin n_fail++;
      $display("FAIL rotate_count: got %0d/%0d want 8", q_obsg.size(), q_rspg.size()); end
    for (int k = 0; k < q_obsg.size() && k < q_rspg.size(); k++) begin
      n_cmp++; if (q_obsg[k] !== k % 4 || q_rspg[k] !== k % 4 || q_grant[k] !== k % 4) begin n_fail++;
        $display("FAIL rotate_grant[%0d]: ready=%0d resp=%0d grant=%0d want %0d", k, q_obsg[k], q_rspg[k], q_grant[k], k % 4); end
      n_cmp++; if (q_obsz[k] !== q_expz[k]) begin n_fail++;
        $display("FAIL rotate_z[%0d]: got %h want %h", k, q_obsz[k], q_expz[k]); end
    end
  endtask

  task automatic test_stall();
    int xa0, xz0;
    xa0 = n_xa; xz0 = n_xz;
    lat = 3; stall_a = 20; stall_z = 20;
    drive_ops(4'b0010, 1, 0, 0);
    stall_a = 0; stall_z = 0;
    n_cmp++; if (q_obsz.size() != 1 || q_obsg.size() != 1 || q_obsg[0] !== 1 || q_obsz[0] !== q_expz[0]) begin n_fail++;
      $display("FAIL stall_result: ops=%0d want 1 with correct sum", q_obsz.size()); end
    n_cmp++; if (n_xa - xa0 !== 1 || n_xz - xz0 !== 1) begin n_fail++;
      $display("FAIL stall_transfers: a=%0d z=%0d want 1/1", n_xa - xa0, n_xz - xz0); end
    n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations want 0", hold_viol); end
    n_cmp++; if (a_run_max < 21 || z_run_max < 20) begin n_fail++;
      $display("FAIL stall_run: a_stb run %0d z_ack run %0d want >=21/>=20", a_run_max, z_run_max); end
  endtask

  task automatic test_ack_delay();
    logic ok; int bad;
    bad = 0;
    new_pair(0, $urandom, $urandom);
    wait_ready(ok);
    req_valid = '0;
    wait_resp(ok);
    n_cmp++; if (!ok || resp_z !== (ra[0] ^ rb[0])) begin n_fail++;
      $display("FAIL ackdly_z0: got %h want %h", resp_z, ra[0] ^ rb[0]); end
    new_pair(2, $urandom, $urandom);
    repeat (15) begin
      @(posedge clk); #1;
      if (req_ready !== '0 || busy !== 1'b1 || resp_valid !== 4'b0001) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL ackdly_hold: got %0d bad cycles want 0", bad); end
    resp_ack = 4'b0001;
    @(posedge clk); #1;
    resp_ack = '0;
    n_cmp++; if (busy !== 1'b0 || req_ready !== '0) begin n_fail++;
      $display("FAIL ackdly_idle: busy=%b ready=%b want 0/0000", busy, req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0100 || grant !== 3'd2) begin n_fail++;
      $display("FAIL ackdly_grant2: ready=%b grant=%0d want 0100/2", req_ready, grant); end
    req_valid = '0;
    wait_resp(ok);
    n_cmp++; if (!ok || resp_valid !== 4'b0100 || resp_z !== (ra[2] ^ rb[2])) begin n_fail++;
      $display("FAIL ackdly_z2: valid=%b z=%h want 0100/%h", resp_valid, resp_z, ra[2] ^ rb[2]); end
    resp_ack = 4'b0100;
    @(posedge clk); #1;
    resp_ack = '0;
  endtask

  task automatic test_rst_mid();
    logic ok; int c;
    c = 0;
    new_pair(1, $urandom, $urandom);
    wait_ready(ok);
    req_valid = '0;
    while (add_z_ack !== 1'b1 && c < 200) begin @(posedge clk); #1; c++; end
    n_cmp++; if (add_z_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_waitz: add_z_ack=%b want 1", add_z_ack); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_last = NREQ - 1;
    n_cmp++; if ({add_a_stb, add_b_stb, add_z_ack, busy} !== 4'b0 || {req_ready, resp_valid} !== '0) begin n_fail++;
      $display("FAIL rstmid_ctrl: strobes=%b rdy/vld=%h want 0", {add_a_stb, add_b_stb, add_z_ack, busy}, {req_ready, resp_valid}); end
    n_cmp++; if ({add_a, add_b, resp_z} !== 96'h0 || grant !== 3'd0 || op_count !== '0) begin n_fail++;
      $display("FAIL rstmid_data: data=%h grant=%0d op_count=%0d want 0", {add_a, add_b, resp_z}, grant, op_count); end
    new_pair(0, $urandom, $urandom);
    wait_ready(ok);
    n_cmp++; if (!ok || req_ready !== 4'b0001 || grant !== 3'd0) begin n_fail++;
      $display("FAIL rstmid_regrant: ready=%b grant=%0d want 0001/0", req_ready, grant); end
    req_valid = '0;
    wait_resp(ok);
    n_cmp++; if (!ok || resp_z !== (ra[0] ^ rb[0])) begin n_fail++;
      $display("FAIL rstmid_z: got %h want %h", resp_z, ra[0] ^ rb[0]); end
    resp_ack = 4'b0001;
    @(posedge clk); #1;
    resp_ack = '0;
  endtask

  task automatic test_wrap_random();
    do_reset();
    lat = $urandom_range(3, 10);
    drive_ops(4'hF, 17, 3, 3);
    n_cmp++; if (q_obsg.size() != 17 || q_rspg.size() != 17) begin n_fail++;
      $display("FAIL wrap_count: got %0d/%0d want 17", q_obsg.size(), q_rspg.size()); end
    for (int k = 0; k < q_obsg.size() && k < q_rspg.size(); k++) begin
      n_cmp++; if (q_obsg[k] !== q_expg[k] || q_grant[k] !== q_expg[k] || q_rspg[k] !== q_expg[k]) begin n_fail++;
        $display("FAIL wrap_grant[%0d]: ready=%0d grant=%0d resp=%0d want %0d", k, q_obsg[k], q_grant[k], q_rspg[k], q_expg[k]); end
      n_cmp++; if (q_obsz[k] !== q_expz[k]) begin n_fail++;
        $display("FAIL wrap_z[%0d]: got %h want %h", k, q_obsz[k], q_expz[k]); end
    end
    n_cmp++; if (op_count !== 4'd1) begin n_fail++; $display("FAIL wrap_op_count: got %0d want 1", op_count); end
    n_cmp++; if (excl_viol !== 0 || hold_viol !== 0) begin n_fail++;
      $display("FAIL protocol: exclusive=%0d hold=%0d violations want 0/0", excl_viol, hold_viol); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; resp_ack = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_ack_delay();
    test_rst_mid();
    test_wrap_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
